cc_miss_fill_fsm: RTL and testbench

- Sequences a cache-line refill for the cache controller.
- Pops one miss request (tag, index) from the miss-request FIFO and issues one AXI INCR read burst to memory.
- Assembles the returning beats into a 64-byte line buffer, then writes the line and its tag into the tag/data arrays in a single cycle.
- Sits between the miss-request FIFO (fed by the address decoder) and the memory-side AXI read port. One outstanding miss at a time.

---
 rtl/cc_pkg.sv | 25 ++
 rtl/cc_line_buffer.sv | 30 +++
 rtl/cc_miss_fill_fsm.sv | 136 +++++++++++++
 tb/tb_cc_miss_fill_fsm.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cc_pkg.sv
// Shared types and constants for the cache-controller miss/refill path.
// Line geometry is derived from the tag/index/offset split of a 32-bit address.
package cc_pkg;

   localparam int unsigned TAG_W  = 17;
   localparam int unsigned IDX_W  = 9;
   localparam int unsigned OFF_W  = 6;
   localparam int unsigned MEM_DW = 64;
   localparam int unsigned LINE_W = (2 ** OFF_W) * 8;
   localparam int unsigned BEATS  = LINE_W / MEM_DW;
   localparam int unsigned CNT_W  = $clog2(BEATS);

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
   localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
   localparam logic [3:0] AXI_LEN_LINE   = 4'(BEATS - 1);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      RECV,
      FILL
   } cc_fill_state_e;

endpackage

// File: rtl/cc_line_buffer.sv
// Line assembly buffer: BEATS slots of MEM_DW bits, one slot written per beat,
// presented as a flat line with slot k at bits [k*MEM_DW +: MEM_DW].
module cc_line_buffer
   import cc_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_wr_en,
   input  logic [CNT_W-1:0]  i_wr_slot,
   input  logic [MEM_DW-1:0] i_wr_data,
   output logic [LINE_W-1:0] o_line
);

   logic [MEM_DW-1:0] r_slot [BEATS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < BEATS; k++) begin
            r_slot[k] <= '0;
         end
      end else if (i_wr_en) begin
         r_slot[i_wr_slot] <= i_wr_data;
      end
   end

   for (genvar g = 0; g < BEATS; g++) begin : g_flat
      assign o_line[g*MEM_DW +: MEM_DW] = r_slot[g];
   end

endmodule

// File: rtl/cc_miss_fill_fsm.sv
// Cache-line refill sequencer: pops one miss, issues one INCR read burst, assembles
// the beats and writes line plus tag into the arrays in a single FILL cycle.
module cc_miss_fill_fsm
   import cc_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              miss_req_valid_i,
   input  logic [TAG_W-1:0]  miss_req_tag_i,
   input  logic [IDX_W-1:0]  miss_req_index_i,
   output logic              miss_req_ready_o,
   output logic [31:0]       mem_araddr_o,
   output logic [3:0]        mem_arlen_o,
   output logic [2:0]        mem_arsize_o,
   output logic [1:0]        mem_arburst_o,
   output logic              mem_arvalid_o,
   input  logic              mem_arready_i,
   input  logic [MEM_DW-1:0] mem_rdata_i,
   input  logic [1:0]        mem_rresp_i,
   input  logic              mem_rlast_i,
   input  logic              mem_rvalid_i,
   output logic              mem_rready_o,
   output logic              fill_wren_o,
   output logic [IDX_W-1:0]  fill_index_o,
   output logic [TAG_W-1:0]  fill_tag_o,
   output logic [LINE_W-1:0] fill_data_o,
   output logic              fill_err_o,
   output logic              busy_o
);

   cc_fill_state_e     r_state;
   cc_fill_state_e     w_state_next;
   logic [TAG_W-1:0]   r_tag;
   logic [IDX_W-1:0]   r_index;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_err;

   logic               w_accept;
   logic               w_ar_hs;
   logic               w_r_hs;
   logic               w_last_beat;
   logic               w_beat_err;

   assign w_accept    = (r_state == IDLE) && miss_req_valid_i;
   assign w_ar_hs     = (r_state == REQ) && mem_arready_i;
   assign w_r_hs      = (r_state == RECV) && mem_rvalid_i;
   assign w_last_beat = (r_cnt == CNT_W'(BEATS - 1));
   // rlast is only checked for consistency; the beat count alone ends the burst.
   assign w_beat_err  = (mem_rresp_i != AXI_RESP_OKAY) || (mem_rlast_i != w_last_beat);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tag   <= '0;
         r_index <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_tag   <= miss_req_tag_i;
            r_index <= miss_req_index_i;
            r_err   <= 1'b0;
         end
         if (w_ar_hs) begin
            r_cnt <= '0;
         end
         if (w_r_hs) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_beat_err) begin
               r_err <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      w_state_next     = r_state;
      miss_req_ready_o = 1'b0;
      mem_arvalid_o    = 1'b0;
      mem_rready_o     = 1'b0;
      fill_wren_o      = 1'b0;
      fill_err_o       = 1'b0;
      case (r_state)
         IDLE: begin
            // Held low while reset is asserted so nothing is popped during reset.
            miss_req_ready_o = !rst;
            if (miss_req_valid_i) begin
               w_state_next = REQ;
            end
         end
         REQ: begin
            mem_arvalid_o = 1'b1;
            if (mem_arready_i) begin
               w_state_next = RECV;
            end
         end
         RECV: begin
            mem_rready_o = 1'b1;
            if (mem_rvalid_i && w_last_beat) begin
               w_state_next = FILL;
            end
         end
         FILL: begin
            fill_wren_o  = 1'b1;
            fill_err_o   = r_err;
            w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   assign mem_araddr_o  = {r_tag, r_index, {OFF_W{1'b0}}};
   assign mem_arlen_o   = AXI_LEN_LINE;
   assign mem_arsize_o  = AXI_SIZE_8B;
   assign mem_arburst_o = AXI_BURST_INCR;
   assign fill_index_o  = r_index;
   assign fill_tag_o    = r_tag;
   assign busy_o        = (r_state != IDLE);

   cc_line_buffer u_line_buffer (
      .clk       (clk),
      .rst       (rst),
      .i_wr_en   (w_r_hs),
      .i_wr_slot (r_cnt),
      .i_wr_data (mem_rdata_i),
      .o_line    (fill_data_o)
   );

endmodule

// File: tb/tb_cc_miss_fill_fsm.sv
// Scoreboard bench for cc_miss_fill_fsm: directed misses push expected AR addresses
// and fill records; a negedge monitor pops and compares whenever the DUT presents them.
module tb_cc_miss_fill_fsm;
   import cc_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              miss_req_valid_i;
   logic [TAG_W-1:0]  miss_req_tag_i;
   logic [IDX_W-1:0]  miss_req_index_i;
   logic              miss_req_ready_o;
   logic [31:0]       mem_araddr_o;
   logic [3:0]        mem_arlen_o;
   logic [2:0]        mem_arsize_o;
   logic [1:0]        mem_arburst_o;
   logic              mem_arvalid_o;
   logic              mem_arready_i;
   logic [MEM_DW-1:0] mem_rdata_i;
   logic [1:0]        mem_rresp_i;
   logic              mem_rlast_i;
   logic              mem_rvalid_i;
   logic              mem_rready_o;
   logic              fill_wren_o;
   logic [IDX_W-1:0]  fill_index_o;
   logic [TAG_W-1:0]  fill_tag_o;
   logic [LINE_W-1:0] fill_data_o;
   logic              fill_err_o;
   logic              busy_o;

   cc_miss_fill_fsm dut (
      .clk              (clk),
      .rst              (rst),
      .miss_req_valid_i (miss_req_valid_i),
      .miss_req_tag_i   (miss_req_tag_i),
      .miss_req_index_i (miss_req_index_i),
      .miss_req_ready_o (miss_req_ready_o),
      .mem_araddr_o     (mem_araddr_o),
      .mem_arlen_o      (mem_arlen_o),
      .mem_arsize_o     (mem_arsize_o),
      .mem_arburst_o    (mem_arburst_o),
      .mem_arvalid_o    (mem_arvalid_o),
      .mem_arready_i    (mem_arready_i),
      .mem_rdata_i      (mem_rdata_i),
      .mem_rresp_i      (mem_rresp_i),
      .mem_rlast_i      (mem_rlast_i),
      .mem_rvalid_i     (mem_rvalid_i),
      .mem_rready_o     (mem_rready_o),
      .fill_wren_o      (fill_wren_o),
      .fill_index_o     (fill_index_o),
      .fill_tag_o       (fill_tag_o),
      .fill_data_o      (fill_data_o),
      .fill_err_o       (fill_err_o),
      .busy_o           (busy_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [TAG_W-1:0] tag;
      logic [IDX_W-1:0] idx;
   } req_t;

   typedef struct {
      logic [TAG_W-1:0]  tag;
      logic [IDX_W-1:0]  idx;
      logic [LINE_W-1:0] data;
      logic              err;
      int                lat;
   } fill_t;

   req_t        req_q[$];
   logic [31:0] ar_q[$];
   fill_t       fill_q[$];
   int          acc_q[$];
   int          n_fills  = 0;
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: event not expected or bound expired", name);
   endtask

   // Miss FIFO model: presents the head entry; the monitor pops it on handshake.
   initial begin : fifo_drv
      miss_req_valid_i = 1'b0;
      miss_req_tag_i   = '0;
      miss_req_index_i = '0;
      forever begin
         @(posedge clk);
         #1;
         if (req_q.size() > 0) begin
            miss_req_valid_i = 1'b1;
            miss_req_tag_i   = req_q[0].tag;
            miss_req_index_i = req_q[0].idx;
         end else begin
            miss_req_valid_i = 1'b0;
         end
      end
   end

   initial begin : monitor
      fill_t       f;
      logic        prev_arv;
      logic [31:0] prev_addr;
      prev_arv  = 1'b0;
      prev_addr = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_arv = 1'b0;
         end else begin
            if (miss_req_valid_i && miss_req_ready_o) begin
               acc_q.push_back(cyc);
               void'(req_q.pop_front());
            end
            if (mem_arvalid_o) begin
               if (prev_arv) chk("araddr_stable", mem_araddr_o, prev_addr);
               if (mem_arready_i) begin
                  chk("arlen", mem_arlen_o, 4'd7);
                  chk("arsize", mem_arsize_o, 3'b011);
                  chk("arburst", mem_arburst_o, 2'b01);
                  if (ar_q.size() == 0) fail_now("unexpected_ar");
                  else chk("araddr", mem_araddr_o, ar_q.pop_front());
                  chk("ar_after_prev_fill", n_fills, acc_q.size() - 1);
               end
            end
            prev_arv  = mem_arvalid_o && !mem_arready_i;
            prev_addr = mem_araddr_o;
            if (fill_wren_o) begin
               if (fill_q.size() == 0) begin
                  fail_now("unexpected_wren");
               end else begin
                  f = fill_q.pop_front();
                  chk("fill_data", fill_data_o, f.data);
                  chk("fill_tag", fill_tag_o, f.tag);
                  chk("fill_index", fill_index_o, f.idx);
                  chk("fill_err", fill_err_o, f.err);
                  chk("ready_low_in_fill", miss_req_ready_o, 1'b0);
                  if (n_fills < acc_q.size()) chk("fill_latency", cyc - acc_q[n_fills], f.lat);
                  else fail_now("fill_without_accept");
               end
               n_fills++;
            end
         end
      end
   end

   task automatic expect_miss(input logic [TAG_W-1:0] tag, input logic [IDX_W-1:0] idx,
                              input logic [31:0] addr, input logic [63:0] base,
                              input logic err, input int lat, input logic want_fill);
      req_t  r;
      fill_t f;
      r.tag = tag;
      r.idx = idx;
      req_q.push_back(r);
      ar_q.push_back(addr);
      if (want_fill) begin
         f.tag  = tag;
         f.idx  = idx;
         f.err  = err;
         f.lat  = lat;
         f.data = '0;
         for (int k = 0; k < 8; k++) f.data[k*64 +: 64] = base + 64'(k);
         fill_q.push_back(f);
      end
   endtask

   // Memory side: optional AR stall, optional one-cycle rvalid gap before beat k.
   task automatic mem_txn(input int ar_stall, input logic [7:0] gaps, input int err_beat,
                          input int last_beat, input logic [63:0] base, input int n_beats);
      int n;
      n = 0;
      mem_arready_i = 1'b0;
      while (!mem_arvalid_o && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!mem_arvalid_o) begin
         fail_now("ar_timeout");
         return;
      end
      repeat (ar_stall) begin
         @(posedge clk);
         #1;
      end
      mem_arready_i = 1'b1;
      @(posedge clk);
      #1;
      mem_arready_i = 1'b0;
      for (int k = 0; k < n_beats; k++) begin
         if (gaps[k]) begin
            mem_rvalid_i = 1'b0;
            @(posedge clk);
            #1;
         end
         mem_rvalid_i = 1'b1;
         mem_rdata_i  = base + 64'(k);
         mem_rresp_i  = (k == err_beat) ? 2'b10 : 2'b00;
         mem_rlast_i  = (k == last_beat);
         @(posedge clk);
         #1;
      end
      mem_rvalid_i = 1'b0;
      mem_rlast_i  = 1'b0;
      mem_rresp_i  = 2'b00;
   endtask

   initial begin : stim
      rst           = 1'b1;
      mem_arready_i = 1'b0;
      mem_rdata_i   = '0;
      mem_rresp_i   = 2'b00;
      mem_rlast_i   = 1'b0;
      mem_rvalid_i  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", miss_req_ready_o, 1'b0);
      chk("rst_arvalid", mem_arvalid_o, 1'b0);
      chk("rst_rready", mem_rready_o, 1'b0);
      chk("rst_wren", fill_wren_o, 1'b0);
      chk("rst_err", fill_err_o, 1'b0);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_araddr", mem_araddr_o, 32'h0);
      chk("rst_fill_data", fill_data_o, '0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Single clean miss, no stalls.
      expect_miss(17'h1ABCD, 9'h055, 32'hD5E6_9540, 64'h0, 1'b0, 10, 1'b1);
      mem_txn(0, 8'h00, -1, 7, 64'h0, 8);

      // AR held off 5 cycles, rvalid toggling.
      expect_miss(17'h00F0F, 9'h1FF, 32'h0787_FFC0, 64'hA5A5_0000_0000_0100, 1'b0, 19, 1'b1);
      mem_txn(5, 8'b1010_1010, -1, 7, 64'hA5A5_0000_0000_0100, 8);

      // SLVERR on beat 3, then a clean miss must report no error.
      expect_miss(17'h12345, 9'h000, 32'h91A2_8000, 64'h1111_2222_3333_0000, 1'b1, 10, 1'b1);
      mem_txn(0, 8'h00, 3, 7, 64'h1111_2222_3333_0000, 8);
      expect_miss(17'h00001, 9'h001, 32'h0000_8040, 64'h0BAD_F00D_0000_0010, 1'b0, 10, 1'b1);
      mem_txn(0, 8'h00, -1, 7, 64'h0BAD_F00D_0000_0010, 8);

      // rlast early on beat 5: all 8 beats still taken, error flagged.
      expect_miss(17'h1FFFF, 9'h100, 32'hFFFF_C000, 64'hDEAD_BEEF_0000_0020, 1'b1, 10, 1'b1);
      mem_txn(0, 8'h00, -1, 5, 64'hDEAD_BEEF_0000_0020, 8);

      // Back-to-back: both entries queued before the first pop.
      expect_miss(17'h0AAAA, 9'h0AA, 32'h5555_2A80, 64'h0101_0101_0000_0000, 1'b0, 10, 1'b1);
      expect_miss(17'h15555, 9'h155, 32'hAAAA_D540, 64'h0202_0202_0000_0000, 1'b0, 10, 1'b1);
      mem_txn(0, 8'h00, -1, 7, 64'h0101_0101_0000_0000, 8);
      mem_txn(0, 8'h00, -1, 7, 64'h0202_0202_0000_0000, 8);
      if (acc_q.size() >= 2) chk("b2b_pop_gap", acc_q[acc_q.size()-1] - acc_q[acc_q.size()-2], 11);
      else fail_now("b2b_pops");

      // Reset in RECV after 4 beats: no fill, everything back to reset values.
      expect_miss(17'h00077, 9'h077, 32'h003B_9DC0, 64'h7777_0000_0000_0000, 1'b0, 0, 1'b0);
      mem_txn(0, 8'h00, -1, 7, 64'h7777_0000_0000_0000, 4);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_ready", miss_req_ready_o, 1'b0);
      @(posedge clk);
      @(negedge clk);
      chk("abort_busy", busy_o, 1'b0);
      chk("abort_rready", mem_rready_o, 1'b0);
      chk("abort_arvalid", mem_arvalid_o, 1'b0);
      chk("abort_wren", fill_wren_o, 1'b0);
      chk("abort_line_cleared", fill_data_o, '0);
      chk("abort_tag", fill_tag_o, '0);
      // The aborted miss never fills, so drop its accept from latency bookkeeping.
      acc_q.delete(acc_q.size() - 1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      expect_miss(17'h0C0DE, 9'h0EE, 32'h606F_3B80, 64'hC0DE_0000_0000_0040, 1'b0, 10, 1'b1);
      mem_txn(0, 8'h00, -1, 7, 64'hC0DE_0000_0000_0040, 8);

      for (int i = 0; i < 100 && fill_q.size() > 0; i++) @(posedge clk);
      if (fill_q.size() > 0) fail_now("fill_timeout");
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("ar_queue_drained", ar_q.size(), 0);
      chk("idle_at_end", busy_o, 1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
